div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL provide one clock and an asynchronous, active-low reset: i_clk, i_rst_n.
REQ-002 SHALL have these ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_signed  in  1  1 = signed (two's-complement) divide; 0 = unsigned.
- i_op_0  in  32  dividend.
- i_op_1  in  32  divisor.
- i_start  in  1  request from the ex stage; held high until the result is consumed.
- i_annul  in  1  cancel request (branch/flush); aborts an in-flight divide.
- o_result  out  64  {remainder[63:32], quotient[31:0]}.
- o_ready  out  1  o_result is valid.

Function
REQ-003 SHALL implement a 4-state FSM: FREE, BYZERO, ON, END.
REQ-004 In FREE with i_start=1 and i_annul=0:
- SHALL latch i_signed, i_op_0 and i_op_1.
- If i_op_1==0, SHALL go to BYZERO; otherwise SHALL go to ON and clear the 6-bit iteration counter.
REQ-005 In FREE with i_start=0 or i_annul=1, SHALL stay in FREE with o_ready=0 and o_result=0.
REQ-006 In signed mode, SHALL latch the magnitude (two's complement) of each negative operand, plus the sign of each original operand.
REQ-007 SHALL ignore operand changes after the latch edge.
REQ-008 Datapath per ON cycle with counter != 32 (65-bit working register W, initialised to {32'b0, |dividend|, 1'b0}):
- Compute the 33-bit trial T = W[64:32] - {1'b0, |divisor|}.
- If T[32]==1, SHALL set W = {W[63:0], 1'b0}.
- Otherwise SHALL set W = {T[31:0], W[31:0], 1'b1}.
- SHALL increment the counter.
REQ-009 In ON with counter==32, SHALL finalise the result:
- quotient = W[31:0], negated if signed mode and the operand signs differ.
- remainder = W[64:33], negated if signed mode and the dividend is negative.
- SHALL register o_result and set o_ready=1, then go to END.
REQ-010 In ON, i_annul=1 SHALL force FREE on the next edge with o_ready=0 and o_result=0, taking priority over any iteration or finalisation.
REQ-011 In BYZERO, SHALL go to END with o_result=0 and o_ready=1 on the next edge; i_annul=1 in BYZERO SHALL force FREE instead.
REQ-012 In END:
- While i_start=1, SHALL hold o_ready=1 and o_result unchanged.
- When i_start=0, SHALL go to FREE and clear o_ready and o_result on that edge.
- i_annul SHALL be ignored in END.
REQ-013 Latency, counting the edge that samples i_start in FREE as edge 1:
- Nonzero divisor: o_ready rises after edge 34.
- Zero divisor: o_ready rises after edge 2.
REQ-014 The signed corner case -2^31 / -1 SHALL yield quotient 0x80000000 and remainder 0, with no trap and no special-case logic.
REQ-015 After returning to FREE, a new i_start SHALL be accepted on the very next edge.
REQ-016 o_ready and o_result SHALL be registered outputs, with no combinational path from any input.

Reset
REQ-017 i_rst_n=0 SHALL asynchronously force the following, regardless of the current state, including mid-divide:
- state = FREE
- o_ready = 0
- o_result = 0
- counter = 0
- W = 0
- latched operands and sign flags = 0
REQ-018 After reset release, the block SHALL accept i_start on the first rising edge.

Verification
REQ-019 Unsigned 100/7, i_start held high -> o_ready rises after edge 34 with o_result = {32'd2, 32'd14}.
REQ-020 Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0x00000000; unsigned 0xFFFFFFFF / 0x00000010 -> quotient 0x0FFFFFFF, remainder 0xF.
REQ-022 Divisor 0 (any dividend) -> o_ready rises after edge 2 with o_result = 0; dropping i_start -> o_ready = 0 on the next edge.
REQ-023 i_annul pulsed at iteration 10 -> FREE on the next edge and o_ready never asserts; a new 9/3 request issued the following cycle -> quotient 3, remainder 0 after a further 34 edges.
REQ-024 i_rst_n asserted at iteration 20 -> all outputs 0 immediately (before the next clock edge); after release, 50/5 -> quotient 10, remainder 0 with normal latency.

Source files
------------

// File: rtl/div_seq.sv
// Sequential 32-bit divider (restoring, one quotient bit per clock) with signed/unsigned
// modes, divide-by-zero short path, annul support and a hold-until-consumed result.
module div_seq (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_signed,
  input  logic [31:0] i_op_0,
  input  logic [31:0] i_op_1,
  input  logic        i_start,
  input  logic        i_annul,
  output logic [63:0] o_result,
  output logic        o_ready
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state_reg;
  logic [5:0]  cnt_reg;
  logic [64:0] w_reg;
  logic [31:0] dvsr_reg;
  logic        signed_reg;
  logic        sign_0_reg;
  logic        sign_1_reg;
  logic [63:0] result_reg;
  logic        ready_reg;

  logic [31:0] abs_op_0;
  logic [31:0] abs_op_1;
  logic [32:0] trial;
  logic [31:0] quot_fin;
  logic [31:0] rem_fin;

  always_comb begin
    abs_op_0 = (i_signed && i_op_0[31]) ? -i_op_0 : i_op_0;
    abs_op_1 = (i_signed && i_op_1[31]) ? -i_op_1 : i_op_1;
    trial    = w_reg[64:32] - {1'b0, dvsr_reg};
    quot_fin = w_reg[31:0];
    rem_fin  = w_reg[64:33];
    // Signs are applied to the magnitude result; -2^31/-1 falls out naturally as 0x80000000.
    if (signed_reg && (sign_0_reg ^ sign_1_reg)) quot_fin = -w_reg[31:0];
    if (signed_reg && sign_0_reg) rem_fin = -w_reg[64:33];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= FREE;
      cnt_reg    <= 6'd0;
      w_reg      <= 65'd0;
      dvsr_reg   <= 32'd0;
      signed_reg <= 1'b0;
      sign_0_reg <= 1'b0;
      sign_1_reg <= 1'b0;
      result_reg <= 64'd0;
      ready_reg  <= 1'b0;
    end else begin
      case (state_reg)
        FREE: begin
          ready_reg  <= 1'b0;
          result_reg <= 64'd0;
          if (i_start && !i_annul) begin
            signed_reg <= i_signed;
            sign_0_reg <= i_signed & i_op_0[31];
            sign_1_reg <= i_signed & i_op_1[31];
            dvsr_reg   <= abs_op_1;
            w_reg      <= {32'd0, abs_op_0, 1'b0};
            cnt_reg    <= 6'd0;
            state_reg  <= (i_op_1 == 32'd0) ? BYZERO : ON;
          end
        end
        BYZERO: begin
          result_reg <= 64'd0;
          if (i_annul) begin
            ready_reg <= 1'b0;
            state_reg <= FREE;
          end else begin
            ready_reg <= 1'b1;
            state_reg <= END;
          end
        end
        ON: begin
          if (i_annul) begin
            ready_reg  <= 1'b0;
            result_reg <= 64'd0;
            state_reg  <= FREE;
          end else if (cnt_reg == 6'd32) begin
            result_reg <= {rem_fin, quot_fin};
            ready_reg  <= 1'b1;
            state_reg  <= END;
          end else begin
            // A negative trial means the divisor did not fit: shift in a 0 quotient bit.
            if (trial[32]) w_reg <= {w_reg[63:0], 1'b0};
            else           w_reg <= {trial[31:0], w_reg[31:0], 1'b1};
            cnt_reg <= cnt_reg + 6'd1;
          end
        end
        END: begin
          if (!i_start) begin
            ready_reg  <= 1'b0;
            result_reg <= 64'd0;
            state_reg  <= FREE;
          end
        end
        default: state_reg <= FREE;
      endcase
    end
  end

  assign o_result = result_reg;
  assign o_ready  = ready_reg;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: hand-computed quotient/remainder vectors, exact latency,
// hold/release handshake, annul and asynchronous reset behaviour.
module tb_div_seq;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_signed;
  logic [31:0] i_op_0;
  logic [31:0] i_op_1;
  logic        i_start;
  logic        i_annul;
  logic [63:0] o_result;
  logic        o_ready;

  int n_tests = 0;
  int n_fail  = 0;

  div_seq dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_signed (i_signed),
    .i_op_0   (i_op_0),
    .i_op_1   (i_op_1),
    .i_start  (i_start),
    .i_annul  (i_annul),
    .o_result (o_result),
    .o_ready  (o_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request from just after a clock edge, check exact latency, END hold
  // (with annul ignored), then release and check the outputs clear.
  task automatic do_div(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [63:0] exp);
    logic early;
    i_signed = sgn;
    i_op_0   = a;
    i_op_1   = b;
    i_start  = 1'b1;
    early    = 1'b0;
    for (int k = 1; k < lat; k++) begin
      @(posedge i_clk); #1;
      if (o_ready) early = 1'b1;
      if (k == 1) begin
        i_op_0   = ~a;
        i_op_1   = 32'd0;
        i_signed = ~sgn;
      end
    end
    check({name, " early"}, {63'd0, early}, 64'd0);
    @(posedge i_clk); #1;
    check({name, " ready"}, {63'd0, o_ready}, 64'd1);
    check({name, " result"}, o_result, exp);
    $display("[TB] %s: result=%h ready=%0b after edge %0d", name, o_result, o_ready, lat);
    i_annul = 1'b1;
    @(posedge i_clk); #1;
    i_annul = 1'b0;
    check({name, " hold ready"}, {63'd0, o_ready}, 64'd1);
    check({name, " hold result"}, o_result, exp);
    i_start = 1'b0;
    @(posedge i_clk); #1;
    check({name, " drop ready"}, {63'd0, o_ready}, 64'd0);
    check({name, " drop result"}, o_result, 64'd0);
  endtask

  initial begin
    i_rst_n  = 1'b0;
    i_signed = 1'b0;
    i_op_0   = 32'd0;
    i_op_1   = 32'd0;
    i_start  = 1'b0;
    i_annul  = 1'b0;
    #1;
    check("reset ready", {63'd0, o_ready}, 64'd0);
    check("reset result", o_result, 64'd0);
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    do_div("u 100/7", 1'b0, 32'd100, 32'd7, 34, {32'd2, 32'd14});
    do_div("s -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 34, {32'hFFFFFFFF, 32'hFFFFFFFD});
    do_div("s min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 34, {32'h0, 32'h80000000});
    do_div("u ffffffff/16", 1'b0, 32'hFFFFFFFF, 32'h10, 34, {32'hF, 32'h0FFFFFFF});
    do_div("u 12345/0", 1'b0, 32'd12345, 32'd0, 2, 64'd0);
    do_div("s -5/0", 1'b1, 32'hFFFFFFFB, 32'd0, 2, 64'd0);
    do_div("s 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 34, {32'd1, 32'hFFFFFFFD});
    do_div("u fffffff9/2", 1'b0, 32'hFFFFFFF9, 32'd2, 34, {32'd1, 32'h7FFFFFFC});
    do_div("s -100/7", 1'b1, 32'hFFFFFF9C, 32'd7, 34, {32'hFFFFFFFE, 32'hFFFFFFF2});
    do_div("u 5/9", 1'b0, 32'd5, 32'd9, 34, {32'd5, 32'd0});

    // Annul after 10 iterations: edge 1 latches, edges 2..11 iterate.
    i_signed = 1'b0; i_op_0 = 32'd100; i_op_1 = 32'd7; i_start = 1'b1;
    repeat (11) @(posedge i_clk);
    #1;
    i_annul = 1'b1;
    @(posedge i_clk); #1;
    i_annul = 1'b0;
    i_start = 1'b0;
    check("annul ready", {63'd0, o_ready}, 64'd0);
    check("annul result", o_result, 64'd0);
    $display("[TB] annul at iteration 10: ready=%0b result=%h", o_ready, o_result);
    do_div("u 9/3 after annul", 1'b0, 32'd9, 32'd3, 34, {32'd0, 32'd3});

    // Asynchronous reset while a result is being held.
    i_signed = 1'b0; i_op_0 = 32'd77; i_op_1 = 32'd0; i_start = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check("end pre-reset ready", {63'd0, o_ready}, 64'd1);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("end async reset ready", {63'd0, o_ready}, 64'd0);
    check("end async reset result", o_result, 64'd0);
    $display("[TB] async reset in END: ready=%0b result=%h", o_ready, o_result);
    i_start = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // Asynchronous reset mid-divide at iteration 20.
    i_signed = 1'b0; i_op_0 = 32'd100; i_op_1 = 32'd7; i_start = 1'b1;
    repeat (21) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("mid async reset ready", {63'd0, o_ready}, 64'd0);
    check("mid async reset result", o_result, 64'd0);
    $display("[TB] async reset at iteration 20: ready=%0b result=%h", o_ready, o_result);
    i_start = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    do_div("u 50/5 after reset", 1'b0, 32'd50, 32'd5, 34, {32'd0, 32'd10});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
